// File: rtl/demorgan_pkg.sv
// Shared types and golden model for the demorgan gate-block checker.
// Output index order matches the err_map bit layout: bit = combo*OUTS + k.
package demorgan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int COMBOS = 4;
   localparam int OUTS   = 6;
   localparam int ERR_W  = COMBOS * OUTS;

   localparam int K_NA     = 0;
   localparam int K_NB     = 1;
   localparam int K_NANDNB = 2;
   localparam int K_NORNB  = 3;
   localparam int K_NAORB  = 4;
   localparam int K_NANDAB = 5;

   function automatic logic [OUTS-1:0] golden(input logic a, input logic b);
      logic [OUTS-1:0] g;
      g[K_NA]     = ~a;
      g[K_NB]     = ~b;
      g[K_NANDNB] = ~a & ~b;
      g[K_NORNB]  = ~a | ~b;
      g[K_NAORB]  = ~(a | b);
      g[K_NANDAB] = ~(a & b);
      return g;
   endfunction

   function automatic logic [2:0] popcount6(input logic [OUTS-1:0] v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < OUTS; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/demorgan_checker.sv
// Sequences all A/B combinations into a demorgan block, waits a settle interval,
// and accumulates a per-combination, per-output error map and pass verdict.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// SETTLE | combination applied, settle timer counting down
// CHECK  | sample the six block outputs against golden, advance combination
// DONE   | one-cycle completion pulse, verdict latched
module demorgan_checker
   import demorgan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             test_a,
   output logic             test_b,
   input  logic             nA,
   input  logic             nB,
   input  logic             nAandnB,
   input  logic             nAornB,
   input  logic             n_AorB,
   input  logic             n_AandB,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_map,
   output logic [4:0]       fail_count
);

   localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ERR_W-1:0] err_map_d;
   logic [4:0]       fail_count_d;
   logic             pass_d;
   logic             test_a_d, test_b_d;
   logic [1:0]       combo;
   logic [OUTS-1:0]  obs;
   logic [OUTS-1:0]  mism;

   // The driven inputs are the combination index itself, so no separate counter.
   assign combo = {test_a, test_b};

   assign obs[K_NA]     = nA;
   assign obs[K_NB]     = nB;
   assign obs[K_NANDNB] = nAandnB;
   assign obs[K_NORNB]  = nAornB;
   assign obs[K_NAORB]  = n_AorB;
   assign obs[K_NANDAB] = n_AandB;

   assign mism = obs ^ golden(test_a, test_b);

   assign busy = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
   assign done = (state_q == ST_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         err_map    <= '0;
         fail_count <= '0;
         pass       <= 1'b0;
         test_a     <= 1'b0;
         test_b     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         err_map    <= err_map_d;
         fail_count <= fail_count_d;
         pass       <= pass_d;
         test_a     <= test_a_d;
         test_b     <= test_b_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      err_map_d    = err_map;
      fail_count_d = fail_count;
      pass_d       = pass;
      test_a_d     = test_a;
      test_b_d     = test_b;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               err_map_d    = '0;
               fail_count_d = '0;
               pass_d       = 1'b0;
               test_a_d     = 1'b0;
               test_b_d     = 1'b0;
               cnt_d        = SETTLE_LOAD;
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            err_map_d    = err_map | (ERR_W'(mism) << (OUTS * int'(combo)));
            fail_count_d = fail_count + 5'(popcount6(mism));
            if (combo == 2'd3) begin
               // Verdict must include the final combination's mismatches.
               pass_d  = (err_map_d == '0);
               state_d = ST_DONE;
            end else begin
               {test_a_d, test_b_d} = combo + 2'd1;
               cnt_d                = SETTLE_LOAD;
               state_d              = ST_SETTLE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_demorgan_checker.sv
// Bench for demorgan_checker: two instances (settle 1 and 3) driving a behavioural
// demorgan block with selectable faults, checked every cycle against a timing model.
module tb_demorgan_checker;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   int   mode = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   logic        ta1, tb1, busy1, done1, pass1;
   logic [23:0] em1;
   logic [4:0]  fc1;
   logic [5:0]  g1;
   logic        ta3, tb3, busy3, done3, pass3;
   logic [23:0] em3;
   logic [4:0]  fc3;
   logic [5:0]  g3;

   function automatic logic [5:0] truth(input logic a, input logic b);
      logic [5:0] t;
      t[0] = !a;
      t[1] = !b;
      t[2] = !a && !b;
      t[3] = !a || !b;
      t[4] = !(a || b);
      t[5] = !(a && b);
      return t;
   endfunction

   // mode 0: healthy block, 1: nA stuck at 0, 2: n_AorB and n_AandB swapped
   function automatic logic [5:0] gate(input logic a, input logic b, input int m);
      logic [5:0] r;
      logic [5:0] t;
      t = truth(a, b);
      r = t;
      if (m == 1) r[0] = 1'b0;
      else if (m == 2) begin
         r[4] = t[5];
         r[5] = t[4];
      end
      return r;
   endfunction

   function automatic logic [23:0] exp_err(input int m, input int n);
      logic [23:0] e;
      logic [1:0]  cc;
      e = '0;
      for (int c = 0; c < n; c++) begin
         cc = 2'(c);
         e[c*6 +: 6] = truth(cc[1], cc[0]) ^ gate(cc[1], cc[0], m);
      end
      return e;
   endfunction

   always_comb g1 = gate(ta1, tb1, mode);
   always_comb g3 = gate(ta3, tb3, mode);

   demorgan_checker #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .test_a(ta1), .test_b(tb1),
      .nA(g1[0]), .nB(g1[1]), .nAandnB(g1[2]), .nAornB(g1[3]), .n_AorB(g1[4]), .n_AandB(g1[5]),
      .busy(busy1), .done(done1), .pass(pass1), .err_map(em1), .fail_count(fc1)
   );

   demorgan_checker #(.SETTLE_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .test_a(ta3), .test_b(tb3),
      .nA(g3[0]), .nB(g3[1]), .nAandnB(g3[2]), .nAornB(g3[3]), .n_AorB(g3[4]), .n_AandB(g3[5]),
      .busy(busy3), .done(done3), .pass(pass3), .err_map(em3), .fail_count(fc3)
   );

   // Model: d = cycles since the accepting edge (-1 = no run since reset).
   int d [2];
   int rmode [2];
   int per [2];
   initial begin
      per[0] = 2;
      per[1] = 4;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         d[0] <= -1;
         d[1] <= -1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (d[i] < 0 || d[i] > 4 * per[i]) begin
               if (start) begin
                  d[i]     <= 0;
                  rmode[i] <= mode;
               end
            end else begin
               d[i] <= d[i] + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_dut(input int i, input logic ta, input logic tb_, input logic bsy,
                            input logic dn, input logic ps, input logic [23:0] em,
                            input logic [4:0] fc);
      int          t;
      int          n;
      logic [23:0] ee;
      logic [1:0]  cb;
      logic        eb, ed, ep;
      string       p;
      p = (i == 0) ? "s1" : "s3";
      t = 4 * per[i];
      if (d[i] < 0) begin
         ee = '0; cb = 2'd0; eb = 1'b0; ed = 1'b0; ep = 1'b0;
      end else begin
         n = d[i] / per[i];
         if (n > 4) n = 4;
         ee = exp_err(rmode[i], n);
         cb = (d[i] < t) ? 2'(d[i] / per[i]) : 2'd3;
         eb = (d[i] < t);
         ed = (d[i] == t);
         ep = (d[i] >= t) && (ee == '0);
      end
      chk({p, ".test_ab"}, 32'({ta, tb_}), 32'(cb));
      chk({p, ".busy"}, 32'(bsy), 32'(eb));
      chk({p, ".done"}, 32'(dn), 32'(ed));
      chk({p, ".pass"}, 32'(ps), 32'(ep));
      chk({p, ".err_map"}, 32'(em), 32'(ee));
      chk({p, ".fail_count"}, 32'(fc), 32'($countones(ee)));
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check_dut(0, ta1, tb1, busy1, done1, pass1, em1, fc1);
         check_dut(1, ta3, tb3, busy3, done3, pass3, em3, fc3);
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, ".s1_outs"}, 32'({ta1, tb1, busy1, done1, pass1, fc1}), 32'd0);
      chk({tag, ".s1_err_map"}, 32'(em1), 32'd0);
      chk({tag, ".s3_outs"}, 32'({ta3, tb3, busy3, done3, pass3, fc3}), 32'd0);
      chk({tag, ".s3_err_map"}, 32'(em3), 32'd0);
   endtask

   // Caller is at a negedge. k counts negedges after the accepting edge.
   task automatic run(input int again_at, input int reset_at, output int t1, output int t3,
                      output int n1, output int n3, output logic [7:0] seq);
      t1 = -1; t3 = -1; n1 = 0; n3 = 0; seq = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         start = (k == again_at);
         if (k < 8 && (k % 2) == 0) seq = {seq[5:0], ta1, tb1};
         if (done1) begin n1++; if (t1 < 0) t1 = k; end
         if (done3) begin n3++; if (t3 < 0) t3 = k; end
         if (k == reset_at) begin
            #2 reset = 1'b1;
            #1 chk_reset("midrun_reset");
            @(negedge clk);
            reset = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   int          t1, t3, n1, n3;
   logic [7:0]  seq;

   initial begin
      #1 reset = 1'b1;
      #1 chk_reset("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      mode = 0;
      run(-1, -1, t1, t3, n1, n3, seq);
      chk("good.s1_done_latency", 32'(t1), 32'd8);
      chk("good.s3_done_latency", 32'(t3), 32'd16);
      chk("good.done_pulses", 32'({n1[3:0], n3[3:0]}), 32'h11);
      chk("good.ab_sequence", 32'(seq), 32'h1B);
      chk("good.s1_err_map", 32'(em1), 32'h0);
      chk("good.s1_fail_count", 32'(fc1), 32'd0);
      chk("good.pass", 32'({pass1, pass3}), 32'b11);

      mode = 1;
      run(-1, -1, t1, t3, n1, n3, seq);
      chk("na_stuck.s1_err_map", 32'(em1), 32'h000041);
      chk("na_stuck.s3_err_map", 32'(em3), 32'h000041);
      chk("na_stuck.fail_count", 32'({fc1, fc3}), {22'd0, 5'd2, 5'd2});
      chk("na_stuck.pass", 32'({pass1, pass3}), 32'b00);

      mode = 2;
      run(-1, -1, t1, t3, n1, n3, seq);
      chk("swap.s1_err_map", 32'(em1), 32'h030C00);
      chk("swap.s3_err_map", 32'(em3), 32'h030C00);
      chk("swap.fail_count", 32'({fc1, fc3}), {22'd0, 5'd4, 5'd4});
      chk("swap.pass", 32'({pass1, pass3}), 32'b00);

      mode = 0;
      run(3, -1, t1, t3, n1, n3, seq);
      chk("restart_busy.s1_latency", 32'(t1), 32'd8);
      chk("restart_busy.s3_latency", 32'(t3), 32'd16);
      chk("restart_busy.done_pulses", 32'({n1[3:0], n3[3:0]}), 32'h11);

      mode = 2;
      run(-1, 5, t1, t3, n1, n3, seq);
      chk("aborted.no_done", 32'({n1[3:0], n3[3:0]}), 32'h00);

      mode = 0;
      run(-1, -1, t1, t3, n1, n3, seq);
      chk("after_reset.s1_latency", 32'(t1), 32'd8);
      chk("after_reset.s3_latency", 32'(t3), 32'd16);
      chk("after_reset.pass", 32'({pass1, pass3}), 32'b11);
      chk("after_reset.err_map", 32'(em1 | em3), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
